// File: rtl/ringbuf_pkg.sv
// Shared constants for the serial ring buffer: sizes and the ramadrs field layout.
package ringbuf_pkg;

    localparam int COUNTER_SIZE = 4;
    localparam int BUFFER_SIZE  = 16;

    // Bit positions inside the packed ramadrs pointer bus
    localparam int RPTR_LSB = 0;
    localparam int WPTR_LSB = COUNTER_SIZE;
    localparam int WRAP_BIT = 2 * COUNTER_SIZE;

endpackage

// File: rtl/ptr_counter.sv
// Wrapping pointer with a phase bit; the phase toggles each time the pointer
// rolls over from its maximum value back to zero.
module ptr_counter #(
    parameter int width = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [width-1:0] ptr,
    output logic             phase
);

    // Advance {phase, ptr} as one width+1 bit counter so the phase flips on wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            phase <= 1'b0;
        end else if (enable) begin
            {phase, ptr} <= {phase, ptr} + 1'b1;
        end
    end

endmodule

// File: rtl/store_ctrl.sv
// Write-side controller of the serial ring buffer. Stores one serial bit per
// write strobe at wptr, advances rptr on read acknowledge, and publishes the
// storage vector, packed pointers and occupancy/error status.
//
// Handshake: instrobe is a write request that is accepted unless the buffer
// is full with no read in the same cycle; outstrobe acknowledges that the
// reader consumed buffer[rptr] and is honoured only when not empty. Requests
// that are refused set the corresponding sticky error flag.
module store_ctrl
    import ringbuf_pkg::*;
#(
    parameter int counter_size = COUNTER_SIZE,
    parameter int buffer_size  = BUFFER_SIZE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      txda,
    input  logic                      instrobe,
    input  logic                      outstrobe,
    output logic [buffer_size-1:0]    buffer,
    output logic [2*counter_size:0]   ramadrs,
    output logic [counter_size:0]     count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow
);

    logic [counter_size-1:0] wptr;
    logic [counter_size-1:0] rptr;
    logic                    wphase;
    logic                    rphase;
    logic                    wrap;
    logic                    ptr_equal;
    logic                    do_write;
    logic                    do_read;

    // Status decode from registered pointer state only
    always_comb begin
        wrap      = wphase ^ rphase;
        ptr_equal = (wptr == rptr);
        empty     = ptr_equal && !wrap;
        full      = ptr_equal && wrap;
        count     = {wrap, wptr} - {1'b0, rptr};
    end

    // A read frees the slot a simultaneous write takes, so full only blocks
    // a write when there is no read in the same cycle
    always_comb begin
        do_write = instrobe && (!full || outstrobe);
        do_read  = outstrobe && !empty;
    end

    ptr_counter #(.width(counter_size)) u_wptr (
        .clock  (clock),
        .reset  (reset),
        .enable (do_write),
        .ptr    (wptr),
        .phase  (wphase)
    );

    ptr_counter #(.width(counter_size)) u_rptr (
        .clock  (clock),
        .reset  (reset),
        .enable (do_read),
        .ptr    (rptr),
        .phase  (rphase)
    );

    // Storage register: only the addressed bit changes; reads never clear data
    always_ff @(posedge clock) begin
        if (reset) begin
            buffer <= '0;
        end else if (do_write) begin
            buffer[wptr] <= txda;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (instrobe && full && !outstrobe) overflow  <= 1'b1;
            if (outstrobe && empty)             underflow <= 1'b1;
        end
    end

    // Packed pointer bus consumed by the read-side decode
    always_comb begin
        ramadrs = '0;
        ramadrs[RPTR_LSB +: counter_size] = rptr;
        ramadrs[WPTR_LSB +: counter_size] = wptr;
        ramadrs[WRAP_BIT]                 = wrap;
    end

endmodule
